// File: rtl/foc_sample_scheduler_pkg.sv
// Shared types and default sizing for the FOC current-sample scheduler.
// Also used by foc_sample_watchdog and the optional FOC_SAMPLE_ERRCNT_EN error counter.
package foc_sample_scheduler_pkg;

    localparam int unsigned DATA_W_DEF  = 12;
    localparam int unsigned DELAY_W_DEF = 8;
    localparam int unsigned DECIM_W_DEF = 4;
    localparam int unsigned TIMEOUT_DEF = 2000;
    localparam int unsigned ERRCNT_W    = 8;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE      = 2'd0;
    localparam state_t ST_DELAY     = 2'd1;
    localparam state_t ST_CUR_BUSY  = 2'd2;
    localparam state_t ST_VOLT_BUSY = 2'd3;

    // Bits needed to count 0 .. limit-1.
    function automatic int unsigned cnt_width(input int unsigned limit);
        return (limit > 1) ? $clog2(limit) : 1;
    endfunction

endpackage

// File: rtl/foc_sample_watchdog.sv
// Clearable transaction watchdog: counts while run is high, flags when TIMEOUT clocks have elapsed.
module foc_sample_watchdog
    import foc_sample_scheduler_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic expired_c
);

    localparam int unsigned CNT_W = cnt_width(TIMEOUT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt;

    // Expiry is seen in the cycle whose registered response lands TIMEOUT clocks after the start.
    assign expired_c = run && (cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (run && !expired_c) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/foc_sample_scheduler.sv
// Schedules current-chain samples per decimated PWM centre and shares the ADC with voltage requests.
// Optional error counter output oErr_cnt enabled by defining FOC_SAMPLE_ERRCNT_EN.
module foc_sample_scheduler
    import foc_sample_scheduler_pkg::*;
#(
    parameter int unsigned DELAY_W = DELAY_W_DEF,
    parameter int unsigned DECIM_W = DECIM_W_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF
) (
    input  logic               iClk,
    input  logic               iRst,
    input  logic               iEnable,
    input  logic               iPwm_center,
    input  logic [DELAY_W-1:0] iDelay,
    input  logic [DECIM_W-1:0] iDecim,
    input  logic               iVolt_req,
    input  logic               iCur_done,
    input  logic               iVolt_done,
    input  logic [DATA_W-1:0]  iId,
    input  logic [DATA_W-1:0]  iIq,
    output logic               oCur_en,
    output logic               oVolt_en,
    output logic [DATA_W-1:0]  oId,
    output logic [DATA_W-1:0]  oIq,
    output logic               oValid,
    output logic               oTimeout,
    output logic               oOverrun,
    output logic               oBusy
`ifdef FOC_SAMPLE_ERRCNT_EN
    ,
    output logic [ERRCNT_W-1:0] oErr_cnt
`endif
);

    state_t             state, state_nxt;
    logic [DECIM_W-1:0] dec_cnt, dec_nxt;
    logic [DELAY_W-1:0] dly_cnt, dly_nxt;
    logic               pend, pend_nxt;
    logic               cur_en_nxt, volt_en_nxt, valid_nxt, timeout_nxt, overrun_nxt, busy_nxt;
    logic [DATA_W-1:0]  id_nxt, iq_nxt;
    logic               qual_c, go_delay_c;
    logic               wd_clear_c, wd_run_c, wd_expired_c;

    assign wd_run_c = (state == ST_CUR_BUSY) || (state == ST_VOLT_BUSY);

    foc_sample_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk       (iClk),
        .rst       (iRst),
        .clear     (wd_clear_c),
        .run       (wd_run_c),
        .expired_c (wd_expired_c)
    );

    // State register and registered outputs.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state    <= ST_IDLE;
            dec_cnt  <= '0;
            dly_cnt  <= '0;
            pend     <= 1'b0;
            oCur_en  <= 1'b0;
            oVolt_en <= 1'b0;
            oId      <= '0;
            oIq      <= '0;
            oValid   <= 1'b0;
            oTimeout <= 1'b0;
            oOverrun <= 1'b0;
            oBusy    <= 1'b0;
        end else begin
            state    <= state_nxt;
            dec_cnt  <= dec_nxt;
            dly_cnt  <= dly_nxt;
            pend     <= pend_nxt;
            oCur_en  <= cur_en_nxt;
            oVolt_en <= volt_en_nxt;
            oId      <= id_nxt;
            oIq      <= iq_nxt;
            oValid   <= valid_nxt;
            oTimeout <= timeout_nxt;
            oOverrun <= overrun_nxt;
            oBusy    <= busy_nxt;
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_nxt   = state;
        dec_nxt     = dec_cnt;
        dly_nxt     = dly_cnt;
        pend_nxt    = pend;
        cur_en_nxt  = 1'b0;
        volt_en_nxt = 1'b0;
        valid_nxt   = 1'b0;
        timeout_nxt = 1'b0;
        overrun_nxt = 1'b0;
        busy_nxt    = 1'b0;
        id_nxt      = oId;
        iq_nxt      = oIq;
        qual_c      = 1'b0;
        go_delay_c  = 1'b0;
        wd_clear_c  = 1'b0;

        if (!iEnable) begin
            dec_nxt = '0;
        end else if (iPwm_center) begin
            if (dec_cnt == iDecim) begin
                qual_c  = 1'b1;
                dec_nxt = '0;
            end else begin
                dec_nxt = dec_cnt + DECIM_W'(1);
            end
        end

        case (state)
            ST_IDLE: begin
                if (qual_c) begin
                    go_delay_c = 1'b1;
                end else if (iVolt_req) begin
                    volt_en_nxt = 1'b1;
                    state_nxt   = ST_VOLT_BUSY;
                end
            end
            ST_DELAY: begin
                overrun_nxt = qual_c;
                if (dly_cnt == '0) begin
                    cur_en_nxt = 1'b1;
                    state_nxt  = ST_CUR_BUSY;
                end else begin
                    dly_nxt = dly_cnt - DELAY_W'(1);
                end
            end
            ST_CUR_BUSY: begin
                overrun_nxt = qual_c;
                if (iCur_done) begin
                    id_nxt    = iId;
                    iq_nxt    = iIq;
                    valid_nxt = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (wd_expired_c) begin
                    timeout_nxt = 1'b1;
                    state_nxt   = ST_IDLE;
                end
            end
            ST_VOLT_BUSY: begin
                overrun_nxt = qual_c && pend;
                if (iVolt_done) begin
                    // A centre arriving with the done is serviced like a pending one.
                    pend_nxt = 1'b0;
                    if (pend || qual_c) begin
                        go_delay_c = 1'b1;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end else if (wd_expired_c) begin
                    timeout_nxt = 1'b1;
                    pend_nxt    = 1'b0;
                    state_nxt   = ST_IDLE;
                end else if (qual_c) begin
                    pend_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        // The delay count is preloaded one short so the start lands iDelay+1 clocks after the trigger.
        if (go_delay_c) begin
            if (iDelay == '0) begin
                cur_en_nxt = 1'b1;
                state_nxt  = ST_CUR_BUSY;
            end else begin
                dly_nxt   = iDelay - DELAY_W'(1);
                state_nxt = ST_DELAY;
            end
        end

        busy_nxt   = (state_nxt != ST_IDLE);
        wd_clear_c = cur_en_nxt || volt_en_nxt;
    end

`ifdef FOC_SAMPLE_ERRCNT_EN
    localparam int unsigned SUM_W = ERRCNT_W + 1;

    logic             enable_q;
    logic [SUM_W-1:0] err_sum_c;

    assign err_sum_c = SUM_W'(oErr_cnt) + SUM_W'(timeout_nxt) + SUM_W'(overrun_nxt);

    // Saturating timeout/overrun tally, restarted on each enable rising edge.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            enable_q <= 1'b0;
            oErr_cnt <= '0;
        end else begin
            enable_q <= iEnable;
            if (iEnable && !enable_q) begin
                oErr_cnt <= '0;
            end else if (err_sum_c[ERRCNT_W]) begin
                oErr_cnt <= '1;
            end else begin
                oErr_cnt <= ERRCNT_W'(err_sum_c);
            end
        end
    end
`endif

endmodule

// File: tb/tb_foc_sample_scheduler.sv
// Self-checking bench for foc_sample_scheduler; event times are predicted from centre times and the
// programmed delay/decimation, and Id/Iq from the values the bench itself drives.
module tb_foc_sample_scheduler;

    localparam int unsigned DELAY_W = 8;
    localparam int unsigned DECIM_W = 4;
    localparam int unsigned TIMEOUT = 100;
    localparam int unsigned DATA_W  = 12;

    logic               iClk;
    logic               iRst;
    logic               iEnable;
    logic               iPwm_center;
    logic [DELAY_W-1:0] iDelay;
    logic [DECIM_W-1:0] iDecim;
    logic               iVolt_req;
    logic               iCur_done;
    logic               iVolt_done;
    logic [DATA_W-1:0]  iId;
    logic [DATA_W-1:0]  iIq;
    logic               oCur_en;
    logic               oVolt_en;
    logic [DATA_W-1:0]  oId;
    logic [DATA_W-1:0]  oIq;
    logic               oValid;
    logic               oTimeout;
    logic               oOverrun;
    logic               oBusy;
`ifdef FOC_SAMPLE_ERRCNT_EN
    logic [7:0]         oErr_cnt;
`endif

    foc_sample_scheduler #(
        .DELAY_W (DELAY_W),
        .DECIM_W (DECIM_W),
        .TIMEOUT (TIMEOUT),
        .DATA_W  (DATA_W)
    ) dut (
        .iClk        (iClk),
        .iRst        (iRst),
        .iEnable     (iEnable),
        .iPwm_center (iPwm_center),
        .iDelay      (iDelay),
        .iDecim      (iDecim),
        .iVolt_req   (iVolt_req),
        .iCur_done   (iCur_done),
        .iVolt_done  (iVolt_done),
        .iId         (iId),
        .iIq         (iIq),
        .oCur_en     (oCur_en),
        .oVolt_en    (oVolt_en),
        .oId         (oId),
        .oIq         (oIq),
        .oValid      (oValid),
        .oTimeout    (oTimeout),
        .oOverrun    (oOverrun),
        .oBusy       (oBusy)
`ifdef FOC_SAMPLE_ERRCNT_EN
        ,
        .oErr_cnt    (oErr_cnt)
`endif
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int cur_q[$];
    int volt_q[$];
    int valid_q[$];
    int to_q[$];
    int ov_q[$];
    logic [DATA_W-1:0] vid_q[$];
    logic [DATA_W-1:0] viq_q[$];
    int cen_q[$];
    logic [DATA_W-1:0] exp_id_q[$];
    logic [DATA_W-1:0] exp_iq_q[$];

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    always @(posedge iClk) cyc <= cyc + 1;

    // Output event recorder, time-stamped with the cycle index.
    always @(negedge iClk) begin
        if (!iRst) begin
            if (oCur_en)  cur_q.push_back(cyc);
            if (oVolt_en) volt_q.push_back(cyc);
            if (oTimeout) to_q.push_back(cyc);
            if (oOverrun) ov_q.push_back(cyc);
            if (oValid) begin
                valid_q.push_back(cyc);
                vid_q.push_back(oId);
                viq_q.push_back(oIq);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge iClk);
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge iClk);
    endtask

    task automatic centre();
        iPwm_center = 1'b1;
        @(negedge iClk);
        iPwm_center = 1'b0;
    endtask

    task automatic clr_q();
        cur_q.delete(); volt_q.delete(); valid_q.delete(); to_q.delete(); ov_q.delete();
        vid_q.delete(); viq_q.delete(); cen_q.delete(); exp_id_q.delete(); exp_iq_q.delete();
    endtask

    // which: 0 oCur_en, 1 oVolt_en, 2 oTimeout; t = -1 if the bound expires.
    task automatic wait_out(input int which, input int limit, output int t);
        int i;
        i = 0;
        t = -1;
        while (t < 0 && i < limit) begin
            @(negedge iClk);
            if ((which == 0 && oCur_en) || (which == 1 && oVolt_en) || (which == 2 && oTimeout))
                t = cyc;
            i++;
        end
    endtask

    task automatic done_pulse(input logic [DATA_W-1:0] id, input logic [DATA_W-1:0] iq);
        iCur_done = 1'b1; iId = id; iIq = iq;
        @(negedge iClk);
        iCur_done = 1'b0;
    endtask

    // Centres every gap clocks; each observed oCur_en answered lat clocks later with random Id/Iq.
    task automatic run_centres(input int n, input int gap, input int lat);
        int done_at;
        done_at = -1;
        for (int k = 0; k < n; k++) begin
            cen_q.push_back(cyc);
            iPwm_center = 1'b1;
            for (int j = 0; j < gap; j++) begin
                @(negedge iClk);
                iPwm_center = 1'b0;
                if (oCur_en) done_at = cyc + lat;
                if (cyc == done_at) begin
                    iCur_done = 1'b1;
                    iId = DATA_W'($urandom);
                    iIq = DATA_W'($urandom);
                    exp_id_q.push_back(iId);
                    exp_iq_q.push_back(iIq);
                end else begin
                    iCur_done = 1'b0;
                end
            end
        end
        iCur_done = 1'b0;
        step(2);
    endtask

    task automatic test_reset();
        iRst = 1'b1;
        step(3);
        checks++;
        if ({oCur_en, oVolt_en, oValid, oTimeout, oOverrun, oBusy, oId, oIq} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h required 0", {oCur_en, oVolt_en, oValid, oTimeout, oOverrun, oBusy, oId, oIq});
        end
`ifdef FOC_SAMPLE_ERRCNT_EN
        checks++;
        if (oErr_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_errcnt: got %0d required 0", oErr_cnt);
        end
`endif
        iRst = 1'b0;
        step(3);
        checks++;
        if (oBusy !== 1'b0 || oCur_en !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: busy %b cur_en %b required 0 0", oBusy, oCur_en);
        end
    endtask

    task automatic test_basic();
        int c, e;
        iEnable = 1'b1; iDecim = '0; iDelay = 8'd5;
        clr_q();
        step(2);
        c = cyc;
        centre();
        step(8);
        e = c + 6;
        checks++;
        if (cur_q.size() !== 1 || cur_q[0] !== e) begin
            errors++;
            $display("FAIL basic_cur_en: got n=%0d t=%0d required n=1 t=%0d", cur_q.size(),
                     (cur_q.size() > 0) ? cur_q[0] : -1, e);
        end
        wait_cyc(e + 40);
        done_pulse(12'h123, 12'hF00);
        step(2);
        checks++;
        if (valid_q.size() !== 1 || valid_q[0] !== e + 41) begin
            errors++;
            $display("FAIL basic_valid_time: got n=%0d t=%0d required n=1 t=%0d", valid_q.size(),
                     (valid_q.size() > 0) ? valid_q[0] : -1, e + 41);
        end
        checks++;
        if (vid_q.size() !== 1 || vid_q[0] !== 12'h123 || viq_q[0] !== 12'hF00) begin
            errors++;
            $display("FAIL basic_data: got id %h iq %h required 123 F00", oId, oIq);
        end
        checks++;
        if (oBusy !== 1'b0) begin
            errors++;
            $display("FAIL basic_idle: busy %b required 0", oBusy);
        end
    endtask

    task automatic test_decim();
        iEnable = 1'b0; step(1); iEnable = 1'b1;
        iDecim = 4'd3; iDelay = 8'd2;
        clr_q();
        step(2);
        run_centres(8, 30, 5);
        checks++;
        if (cur_q.size() !== 2) begin
            errors++;
            $display("FAIL decim_count: got %0d pulses required 2", cur_q.size());
        end else begin
            checks++;
            if (cur_q[0] !== cen_q[3] + 3 || cur_q[1] !== cen_q[7] + 3) begin
                errors++;
                $display("FAIL decim_times: got %0d %0d required %0d %0d", cur_q[0], cur_q[1],
                         cen_q[3] + 3, cen_q[7] + 3);
            end
        end
    endtask

    task automatic test_volt_priority();
        int c, e, d, v, vd, e2;
        iDecim = '0; iDelay = 8'd3;
        clr_q();
        step(2);
        c = cyc;
        iVolt_req = 1'b1;
        centre();
        wait_out(0, 20, e);
        checks++;
        if (e !== c + 4 || volt_q.size() !== 0) begin
            errors++;
            $display("FAIL volt_centre_first: cur_en t=%0d volt_en n=%0d required t=%0d n=0", e, volt_q.size(), c + 4);
        end
        wait_cyc(e + 10);
        d = cyc;
        done_pulse(12'h0AB, 12'h0CD);
        wait_out(1, 10, v);
        iVolt_req = 1'b0;
        checks++;
        if (v !== d + 2) begin
            errors++;
            $display("FAIL volt_after_valid: got t=%0d required t=%0d", v, d + 2);
        end
        step(3);
        centre();
        step(3);
        vd = cyc;
        iVolt_done = 1'b1;
        step(1);
        iVolt_done = 1'b0;
        wait_out(0, 20, e2);
        checks++;
        if (e2 !== vd + 4) begin
            errors++;
            $display("FAIL volt_pending_delay: got t=%0d required t=%0d", e2, vd + 4);
        end
        step(5);
        done_pulse(12'h001, 12'h002);
        step(2);
        checks++;
        if (ov_q.size() !== 0 || valid_q.size() !== 2) begin
            errors++;
            $display("FAIL volt_no_overrun: overruns %0d valids %0d required 0 2", ov_q.size(), valid_q.size());
        end
    endtask

    task automatic test_timeout();
        int c, t;
        iDecim = '0; iDelay = '0;
        clr_q();
        step(2);
        c = cyc;
        centre();
        step(1);
        checks++;
        if (cur_q.size() !== 1 || cur_q[0] !== c + 1) begin
            errors++;
            $display("FAIL zero_delay_cur_en: got n=%0d t=%0d required n=1 t=%0d", cur_q.size(),
                     (cur_q.size() > 0) ? cur_q[0] : -1, c + 1);
        end
        step(3);
        done_pulse(12'hA5A, 12'h5A5);
        step(3);
        c = cyc;
        centre();
        wait_out(2, 150, t);
        checks++;
        if (t !== c + 1 + 100) begin
            errors++;
            $display("FAIL timeout_time: got t=%0d required t=%0d", t, c + 101);
        end
        checks++;
        if (oId !== 12'hA5A || oIq !== 12'h5A5 || oBusy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_hold: got id %h iq %h busy %b required A5A 5A5 0", oId, oIq, oBusy);
        end
        step(2);
        done_pulse(12'h111, 12'h222);
        step(3);
        checks++;
        if (valid_q.size() !== 1 || oId !== 12'hA5A || to_q.size() !== 1) begin
            errors++;
            $display("FAIL late_done_ignored: valids %0d id %h timeouts %0d required 1 A5A 1",
                     valid_q.size(), oId, to_q.size());
        end
    endtask

    task automatic test_overrun();
        int c, e, c2;
        iEnable = 1'b0; step(1); iEnable = 1'b1;
        iDecim = '0; iDelay = 8'd2;
        clr_q();
        step(2);
        c = cyc;
        centre();
        wait_out(0, 20, e);
        step(2);
        c2 = cyc;
        centre();
        step(2);
        checks++;
        if (ov_q.size() !== 1 || ov_q[0] !== c2 + 1) begin
            errors++;
            $display("FAIL overrun_pulse: got n=%0d t=%0d required n=1 t=%0d", ov_q.size(),
                     (ov_q.size() > 0) ? ov_q[0] : -1, c2 + 1);
        end
        done_pulse(12'h321, 12'h654);
        step(3);
        checks++;
        if (cur_q.size() !== 1 || e !== c + 3 || valid_q.size() !== 1) begin
            errors++;
            $display("FAIL overrun_single_start: cur_en n=%0d t=%0d valids %0d required 1 %0d 1",
                     cur_q.size(), e, valid_q.size(), c + 3);
        end
`ifdef FOC_SAMPLE_ERRCNT_EN
        checks++;
        if (oErr_cnt !== 8'd1) begin
            errors++;
            $display("FAIL errcnt_one: got %0d required 1", oErr_cnt);
        end
        iDelay = 8'd255;
        iPwm_center = 1'b1;
        step(320);
        iPwm_center = 1'b0;
        step(150);
        checks++;
        if (oErr_cnt !== 8'd255 || oBusy !== 1'b0) begin
            errors++;
            $display("FAIL errcnt_saturate: got %0d busy %b required 255 0", oErr_cnt, oBusy);
        end
        iEnable = 1'b0; step(1); iEnable = 1'b1; step(2);
        checks++;
        if (oErr_cnt !== 8'd0) begin
            errors++;
            $display("FAIL errcnt_enable_clear: got %0d required 0", oErr_cnt);
        end
`endif
    endtask

    task automatic test_rst_mid();
        int c;
        iDecim = '0; iDelay = 8'd10;
        clr_q();
        step(2);
        centre();
        step(3);
        iRst = 1'b1;
        #1;
        checks++;
        if ({oCur_en, oVolt_en, oValid, oTimeout, oOverrun, oBusy, oId, oIq} !== '0) begin
            errors++;
            $display("FAIL rst_mid_outputs: got %h required 0", {oCur_en, oVolt_en, oValid, oTimeout, oOverrun, oBusy, oId, oIq});
        end
        step(2);
        iRst = 1'b0;
        clr_q();
        step(30);
        done_pulse(12'h777, 12'h888);
        step(3);
        checks++;
        if (cur_q.size() !== 0 || valid_q.size() !== 0) begin
            errors++;
            $display("FAIL rst_mid_quiet: cur_en %0d valids %0d required 0 0", cur_q.size(), valid_q.size());
        end
        c = cyc;
        centre();
        step(14);
        checks++;
        if (cur_q.size() !== 1 || cur_q[0] !== c + 11) begin
            errors++;
            $display("FAIL rst_mid_restart: got n=%0d t=%0d required n=1 t=%0d", cur_q.size(),
                     (cur_q.size() > 0) ? cur_q[0] : -1, c + 11);
        end
        done_pulse(12'h010, 12'h020);
        step(3);
    endtask

    task automatic test_random();
        int d, l, lat, n;
        int exp_cur[$];
        for (int r = 0; r < 4; r++) begin
            d   = $urandom_range(0, 4);
            l   = $urandom_range(0, 20);
            lat = $urandom_range(1, 30);
            n   = $urandom_range(6, 10);
            iEnable = 1'b0; step(1); iEnable = 1'b1;
            iDecim = DECIM_W'(d); iDelay = DELAY_W'(l);
            clr_q();
            exp_cur.delete();
            step(2);
            run_centres(n, 60, lat);
            for (int k = 0; k < n; k++)
                if ((k + 1) % (d + 1) == 0) exp_cur.push_back(cen_q[k] + l + 1);
            checks++;
            if (cur_q.size() !== exp_cur.size() || valid_q.size() !== exp_cur.size() || ov_q.size() !== 0) begin
                errors++;
                $display("FAIL rand_counts r%0d: cur_en %0d valids %0d overruns %0d required %0d %0d 0",
                         r, cur_q.size(), valid_q.size(), ov_q.size(), exp_cur.size(), exp_cur.size());
            end else begin
                for (int i = 0; i < exp_cur.size(); i++) begin
                    checks++;
                    if (cur_q[i] !== exp_cur[i] || valid_q[i] !== exp_cur[i] + lat + 1 ||
                        vid_q[i] !== exp_id_q[i] || viq_q[i] !== exp_iq_q[i]) begin
                        errors++;
                        $display("FAIL rand_txn r%0d i%0d: t=%0d v=%0d id %h iq %h required t=%0d v=%0d id %h iq %h",
                                 r, i, cur_q[i], valid_q[i], vid_q[i], viq_q[i],
                                 exp_cur[i], exp_cur[i] + lat + 1, exp_id_q[i], exp_iq_q[i]);
                    end
                end
            end
        end
    endtask

    initial begin
        iRst = 1'b1; iEnable = 1'b0; iPwm_center = 1'b0; iDelay = '0; iDecim = '0;
        iVolt_req = 1'b0; iCur_done = 1'b0; iVolt_done = 1'b0; iId = '0; iIq = '0;
        test_reset();
        test_basic();
        test_decim();
        test_volt_priority();
        test_timeout();
        test_overrun();
        test_rst_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
